// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard.
//   FWD_RF   : forward-select value meaning "take the operand from the register file"
//   STAGE_EX : scoreboard index of the instruction currently in EX (youngest in-flight entry)
package hazard_scoreboard_pkg;

  localparam int unsigned FWD_RF   = 0;
  localparam int unsigned STAGE_EX = 0;

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Per-source priority encoder over the in-flight write entries.
// Ports:
//   src, use_src         : source register and whether the ID instruction reads it
//   ent_v/ent_dst/ent_load : flattened scoreboard entries, index 0 = youngest (EX)
//   hit, idx, is_load    : youngest matching entry, its index and whether it is a load
module sb_src_match #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic [RA_W-1:0]       src,
  input  logic                  use_src,
  input  logic [DEPTH-1:0]      ent_v,
  input  logic [DEPTH*RA_W-1:0] ent_dst,
  input  logic [DEPTH-1:0]      ent_load,
  output logic                  hit,
  output logic [SEL_W-1:0]      idx,
  output logic                  is_load
);

  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    // Ascending scan keeps the first (youngest) match; $0 never matches.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit && use_src && ent_v[i] && (src != '0) &&
          (ent_dst[i*RA_W +: RA_W] == src)) begin
        hit     = 1'b1;
        idx     = SEL_W'(i);
        is_load = ent_load[i];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding unit sitting beside the ID stage.
// Tracks in-flight register writes in a DEPTH-entry shift register
// (index 0 = EX ... DEPTH-1 = WB), decides stall for the ID instruction and
// registers forward selects for its EX cycle.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   id_valid           : ID holds a real instruction
//   id_rs, id_rt       : ID source registers; id_use_rs/id_use_rt say whether they are read
//   id_is_br           : ID instruction compares operands in ID (BEQ/BNE/JR)
//   id_wreg, id_wdst   : ID instruction writes register id_wdst
//   id_load            : ID instruction is a load
//   flush              : squash the ID instruction
//   stall              : hold PC and IF/ID (combinational)
//   fwd_a, fwd_b       : registered EX operand source (0 = regfile, s = stage-s bus)
//   br_fwd_a, br_fwd_b : combinational ID-branch operand source, same encoding
//   stall_cnt          : saturating stall-cycle count
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RA_W       = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned BR_IN_ID   = 1,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_br,
  input  logic             id_wreg,
  input  logic [RA_W-1:0]  id_wdst,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic [SEL_W-1:0] br_fwd_a,
  output logic [SEL_W-1:0] br_fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH-1:0]      ent_v_q, ent_v_d;
  logic [DEPTH*RA_W-1:0] ent_dst_q, ent_dst_d;
  logic [DEPTH-1:0]      ent_load_q, ent_load_d;
  logic [SEL_W-1:0]      fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]      fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic             hit_a, hit_b, ld_a, ld_b;
  logic [SEL_W-1:0] idx_a, idx_b;
  logic             stall_a, stall_b;
  logic [SEL_W-1:0] sel_a, sel_b, bsel_a, bsel_b;

  sb_src_match #(.RA_W(RA_W), .DEPTH(DEPTH)) u_match_rs (
    .src      (id_rs),
    .use_src  (id_use_rs),
    .ent_v    (ent_v_q),
    .ent_dst  (ent_dst_q),
    .ent_load (ent_load_q),
    .hit      (hit_a),
    .idx      (idx_a),
    .is_load  (ld_a)
  );

  sb_src_match #(.RA_W(RA_W), .DEPTH(DEPTH)) u_match_rt (
    .src      (id_rt),
    .use_src  (id_use_rt),
    .ent_v    (ent_v_q),
    .ent_dst  (ent_dst_q),
    .ent_load (ent_load_q),
    .hit      (hit_b),
    .idx      (idx_b),
    .is_load  (ld_b)
  );

  // EX-operand and ID-branch-operand decode for one source. The EX consumer
  // sees the producer one stage further on (i+1); a branch needs it now (i).
  function automatic void decode_src(
    input  logic             hit,
    input  logic [SEL_W-1:0] idx,
    input  logic             is_load,
    input  logic             is_br,
    output logic             src_stall,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] bsel
  );
    int unsigned i;
    i         = 32'(idx);
    src_stall = 1'b0;
    sel       = SEL_W'(FWD_RF);
    bsel      = SEL_W'(FWD_RF);
    if (hit) begin
      if (FWD_EN != 0) begin
        if (is_load && (i + 1 < LOAD_READY)) src_stall = 1'b1;
        else if (i + 1 < DEPTH)               sel = SEL_W'(i + 1);
      end else begin
        if (i < DEPTH - 1) src_stall = 1'b1;
      end
      if ((BR_IN_ID != 0) && is_br) begin
        if ((i == STAGE_EX) || (is_load && (i < LOAD_READY))) src_stall = 1'b1;
        else if (i < DEPTH - 1)                               bsel = SEL_W'(i);
      end
    end
  endfunction

  always_comb begin
    stall_a = 1'b0;
    stall_b = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    bsel_a  = '0;
    bsel_b  = '0;
    decode_src(hit_a, idx_a, ld_a, id_is_br, stall_a, sel_a, bsel_a);
    decode_src(hit_b, idx_b, ld_b, id_is_br, stall_b, sel_b, bsel_b);
  end

  // Flush dominates: a squashed instruction never stalls.
  assign stall    = id_valid && !flush && (stall_a || stall_b);
  assign br_fwd_a = bsel_a;
  assign br_fwd_b = bsel_b;

  always_comb begin
    ent_v_d    = {ent_v_q[DEPTH-2:0], id_valid && id_wreg && !stall && !flush};
    ent_dst_d  = {ent_dst_q[(DEPTH-1)*RA_W-1:0], id_wdst};
    ent_load_d = {ent_load_q[DEPTH-2:0], id_load};
    fwd_a_d    = (stall || flush) ? '0 : sel_a;
    fwd_b_d    = (stall || flush) ? '0 : sel_b;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v_q     <= '0;
      ent_dst_q   <= '0;
      ent_load_q  <= '0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_v_q     <= ent_v_d;
      ent_dst_q   <= ent_dst_d;
      ent_load_q  <= ent_load_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wdst;
  logic       id_use_rs, id_use_rt, id_is_br, id_wreg, id_load, flush;

  logic        stall0, stall1;
  logic [1:0]  fwd_a0, fwd_b0, br_a0, br_b0;
  logic [1:0]  fwd_a1, fwd_b1, br_a1, br_b1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_br(id_is_br),
    .id_wreg(id_wreg), .id_wdst(id_wdst), .id_load(id_load), .flush(flush),
    .stall(stall0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
    .br_fwd_a(br_a0), .br_fwd_b(br_b0), .stall_cnt(cnt0)
  );

  hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_br(id_is_br),
    .id_wreg(id_wreg), .id_wdst(id_wdst), .id_load(id_load), .flush(flush),
    .stall(stall1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .br_fwd_a(br_a1), .br_fwd_b(br_b1), .stall_cnt(cnt1)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic wr, input logic [4:0] wd, input logic ld);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    id_is_br  = br;
    id_wreg   = wr;
    id_wdst   = wd;
    id_load   = ld;
    #1;
  endtask

  task automatic nop();
    instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    nop();
    repeat (2) step();
    check("reset_fwd_a", fwd_a0, 0);
    check("reset_fwd_b", fwd_b0, 0);
    check("reset_cnt", cnt0, 0);
    check("reset_stall", stall0, 0);
    check("reset_br_fwd_a", br_a0, 0);
    rst = 1'b0;

    // ADD $3,$1,$2 ; ADD $4,$3,$3 -> forward from stage 1
    instr(1, 1, 2, 1, 1, 0, 1, 3, 0);
    step();
    instr(1, 3, 3, 1, 1, 0, 1, 4, 0);
    check("alu_dep_stall", stall0, 0);
    step();
    nop();
    check("alu_dep_fwd_a", fwd_a0, 1);
    check("alu_dep_fwd_b", fwd_b0, 1);
    drain();

    // LW $5,0($1) ; SUB $6,$5,$1 -> one stall, then forward from stage 2
    instr(1, 1, 0, 1, 0, 0, 1, 5, 1);
    step();
    instr(1, 5, 1, 1, 1, 0, 1, 6, 0);
    check("lu_stall_1", stall0, 1);
    step();
    check("lu_bubble_fwd_a", fwd_a0, 0);
    check("lu_stall_2", stall0, 0);
    step();
    nop();
    check("lu_fwd_a", fwd_a0, 2);
    check("lu_fwd_b", fwd_b0, 0);
    check("lu_cnt", cnt0, 1);
    drain();

    // ADD $7 ; BEQ $7,$0 -> one stall, then branch forward from stage 1
    instr(1, 1, 2, 1, 1, 0, 1, 7, 0);
    step();
    instr(1, 7, 0, 1, 1, 1, 0, 0, 0);
    check("br_alu_stall_1", stall0, 1);
    step();
    check("br_alu_stall_2", stall0, 0);
    check("br_alu_br_fwd_a", br_a0, 1);
    check("br_alu_br_fwd_b", br_b0, 0);
    step();
    nop();
    check("br_alu_cnt", cnt0, 2);
    drain();

    // LW $7 ; BEQ $7,$0 -> two stalls, then regfile (WB write-first)
    instr(1, 1, 0, 1, 0, 0, 1, 7, 1);
    step();
    instr(1, 7, 0, 1, 1, 1, 0, 0, 0);
    check("br_lw_stall_1", stall0, 1);
    step();
    check("br_lw_stall_2", stall0, 1);
    step();
    check("br_lw_stall_3", stall0, 0);
    check("br_lw_br_fwd_a", br_a0, 0);
    step();
    nop();
    check("br_lw_cnt", cnt0, 4);
    drain();

    // LW $0 ; ADD $8,$0,$0 -> $0 never creates a hazard
    instr(1, 1, 0, 1, 0, 0, 1, 0, 1);
    step();
    instr(1, 0, 0, 1, 1, 0, 1, 8, 0);
    check("r0_stall", stall0, 0);
    step();
    nop();
    check("r0_fwd_a", fwd_a0, 0);
    drain();

    // ADD $9 ; ADD $11 ; ADD $12,$9 (stage 2) ; ADD $13,$9 (regfile)
    instr(1, 1, 2, 1, 1, 0, 1, 9, 0);
    step();
    instr(1, 1, 2, 1, 1, 0, 1, 11, 0);
    step();
    instr(1, 9, 0, 1, 1, 0, 1, 12, 0);
    check("dist2_stall", stall0, 0);
    step();
    check("dist2_fwd_a", fwd_a0, 2);
    instr(1, 9, 0, 1, 1, 0, 1, 13, 0);
    step();
    nop();
    check("dist3_fwd_a", fwd_a0, 0);
    drain();

    // ADD $14 ; ADD $14 ; ADD $15,$14,$14 -> youngest producer wins
    instr(1, 1, 2, 1, 1, 0, 1, 14, 0);
    step();
    instr(1, 1, 2, 1, 1, 0, 1, 14, 0);
    step();
    instr(1, 14, 14, 1, 1, 0, 1, 15, 0);
    step();
    nop();
    check("youngest_fwd_a", fwd_a0, 1);
    check("youngest_fwd_b", fwd_b0, 1);
    drain();

    // LW $5 ; SUB $6,$5 with flush -> no stall, bubble, count unchanged
    instr(1, 1, 0, 1, 0, 0, 1, 5, 1);
    step();
    flush = 1'b1;
    instr(1, 5, 1, 1, 1, 0, 1, 6, 0);
    check("flush_stall", stall0, 0);
    step();
    flush = 1'b0;
    nop();
    check("flush_fwd_a", fwd_a0, 0);
    check("flush_cnt", cnt0, 4);
    drain();

    // Reset while a load sits in EX with a dependent instruction in ID
    instr(1, 1, 2, 1, 1, 0, 1, 3, 0);
    step();
    instr(1, 3, 0, 1, 0, 0, 1, 5, 1);
    step();
    check("pre_rst_fwd_a", fwd_a0, 1);
    instr(1, 5, 1, 1, 1, 0, 1, 6, 0);
    check("pre_rst_stall", stall0, 1);
    rst = 1'b1;
    step();
    check("rst_stall", stall0, 0);
    check("rst_fwd_a", fwd_a0, 0);
    check("rst_fwd_b", fwd_b0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_cnt_nofwd", cnt1, 0);
    rst = 1'b0;
    #1;
    check("post_rst_stall", stall0, 0);
    step();
    nop();
    check("post_rst_fwd_a", fwd_a0, 0);
    drain();

    // FWD_EN=0: ADD $3 ; OR $8,$3,$2 -> stall until producer reaches WB
    instr(1, 1, 2, 1, 1, 0, 1, 3, 0);
    check("nf_add_stall", stall1, 0);
    step();
    instr(1, 3, 2, 1, 1, 0, 1, 8, 0);
    check("nf_stall_1", stall1, 1);
    step();
    check("nf_stall_2", stall1, 1);
    step();
    check("nf_stall_3", stall1, 0);
    step();
    check("nf_fwd_a", fwd_a1, 0);
    check("nf_fwd_b", fwd_b1, 0);
    check("nf_cnt", cnt1, 2);

    // FWD_EN=0: flush during a stall drops it in the same cycle
    instr(1, 1, 2, 1, 1, 0, 1, 3, 0);
    step();
    instr(1, 3, 2, 1, 1, 0, 1, 8, 0);
    check("nf2_stall_1", stall1, 1);
    step();
    check("nf2_cnt", cnt1, 3);
    check("nf2_stall_2", stall1, 1);
    flush = 1'b1;
    #1;
    check("nf2_flush_stall", stall1, 0);
    step();
    flush = 1'b0;
    check("nf2_flush_cnt", cnt1, 3);

    // 2-bit counter saturates at 3
    instr(1, 1, 2, 1, 1, 0, 1, 20, 0);
    step();
    instr(1, 20, 0, 1, 0, 0, 1, 21, 0);
    check("sat_stall", stall1, 1);
    step();
    check("sat_cnt", cnt1, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
